wb_regfile: RTL and testbench

- General-purpose register file (GRF) that consumes the write-back stage outputs: write enable, destination, write data, PC and Tnew.
- Serves two combinational read ports to the decode stage.
- Bypasses the same-cycle W-stage write into the read ports (write-before-read).
- Keeps a committed-write counter and a sticky protocol-error flag for the verification environment.

---
 rtl/wb_regfile_pkg.sv | 14 +
 rtl/wb_regfile_if.sv | 33 +++
 rtl/wb_regfile_read_port.sv | 30 +++
 rtl/wb_regfile.sv | 108 ++++++++++
 tb/tb_wb_regfile.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back register file.
// Trace and error message formats live here so every user prints the same text.
package wb_regfile_pkg;

    localparam int GRF_AW = 5;
    localparam int ZERO_REG = 0;
    localparam int GRF_DEPTH = 2 ** GRF_AW;

    localparam logic [1:0] TNEW_READY = 2'd0;

    localparam string TRACE_FMT = "@%08h: $%02d <= %08h";
    localparam string ERR_FMT = "GRF ERR @%08h";

endpackage

// File: rtl/wb_regfile_if.sv
// W-stage write bundle, decode read ports and status outputs of the GRF.
// master drives writes and read addresses; slave is the register file.
interface wb_regfile_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CNT_W = 32
);

    logic             RegWE_i;
    logic [AW-1:0]    a3_i;
    logic [DW-1:0]    wd_i;
    logic [31:0]      pc_i;
    logic [1:0]       Tnew_i;
    logic [AW-1:0]    a1_i;
    logic [AW-1:0]    a2_i;
    logic [DW-1:0]    rd1_o;
    logic [DW-1:0]    rd2_o;
    logic [CNT_W-1:0] wcnt_o;
    logic             err_o;

    modport master (
        output RegWE_i, a3_i, wd_i, pc_i, Tnew_i,
        output a1_i, a2_i,
        input  rd1_o, rd2_o, wcnt_o, err_o
    );

    modport slave (
        input  RegWE_i, a3_i, wd_i, pc_i, Tnew_i,
        input  a1_i, a2_i,
        output rd1_o, rd2_o, wcnt_o, err_o
    );

endinterface

// File: rtl/wb_regfile_read_port.sv
// One combinational GRF read port with W-stage write-before-read bypass.
// Register 0 always reads zero regardless of array or bypass contents.
module grf_read_port
    import wb_regfile_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic [AW-1:0] addr,
    input  logic          byp_en,
    input  logic [AW-1:0] byp_addr,
    input  logic [DW-1:0] byp_data,
    input  logic [DW-1:0] arr_data,
    output logic [DW-1:0] rdata
);

    // Select zero, the in-flight write, or the stored value.
    always_comb begin
        rdata = arr_data;
        priority case (1'b1)
            (addr == AW'(ZERO_REG)):
                rdata = '0;
            (byp_en && (addr == byp_addr)):
                rdata = byp_data;
            default:
                rdata = arr_data;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// General-purpose register file fed by the W stage, with commit counter
// and sticky Tnew error flag. Define GRF_TRACE_EN to print commit traces.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    wb_regfile_if.slave  bus
);

    localparam int DEPTH = (AW == GRF_AW) ? GRF_DEPTH : (1 << AW);

    logic [DW-1:0]    regs [DEPTH];
    logic [CNT_W-1:0] wcnt_q;
    logic             err_q;
    logic             commit;
    logic             tnew_bad;
    logic [DW-1:0]    arr1;
    logic [DW-1:0]    arr2;
    logic             unused_pc;

    // Gated by reset so the bypass cannot leak data while the array is held clear.
    assign commit = bus.RegWE_i
                 && (bus.a3_i != AW'(ZERO_REG))
                 && reset;

    assign tnew_bad = bus.RegWE_i
                   && (bus.Tnew_i != TNEW_READY);

    assign unused_pc = ^bus.pc_i;

    // Register array; entry 0 is cleared on reset and never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[bus.a3_i] <= bus.wd_i;
        end
    end

    // Committed-write counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q <= '0;
        end else if (commit) begin
            wcnt_q <= wcnt_q + CNT_W'(1);
        end
    end

    // Sticky flag for writebacks whose result was not ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (tnew_bad) begin
            err_q <= 1'b1;
        end
    end

    assign arr1 = regs[bus.a1_i];
    assign arr2 = regs[bus.a2_i];

    grf_read_port #(
        .DW(DW),
        .AW(AW)
    ) u_rp1 (
        .addr     (bus.a1_i),
        .byp_en   (commit),
        .byp_addr (bus.a3_i),
        .byp_data (bus.wd_i),
        .arr_data (arr1),
        .rdata    (bus.rd1_o)
    );

    grf_read_port #(
        .DW(DW),
        .AW(AW)
    ) u_rp2 (
        .addr     (bus.a2_i),
        .byp_en   (commit),
        .byp_addr (bus.a3_i),
        .byp_data (bus.wd_i),
        .arr_data (arr2),
        .rdata    (bus.rd2_o)
    );

    assign bus.wcnt_o = wcnt_q;
    assign bus.err_o = err_q;

`ifdef GRF_TRACE_EN
    // Commit trace and first-error report, in commit order.
    always @(posedge clk) begin
        if (commit) begin
            $display(TRACE_FMT, bus.pc_i, bus.a3_i, bus.wd_i);
        end
        if (reset && tnew_bad && !err_q) begin
            $display(ERR_FMT, bus.pc_i);
        end
    end
`else
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes model expectations,
// a negedge monitor pops and compares read ports, counter and error flag.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [CW-1:0] wcnt;
        logic          err;
        string         tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [32];
    int unsigned cnt_m;
    bit err_m;

    always #5 clk = ~clk;

    wb_regfile_if #(.DW(DW), .AW(AW), .CNT_W(CW)) bus ();

    wb_regfile #(
        .DW(DW),
        .AW(AW),
        .CNT_W(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] model_rd(
        input bit rst, input bit we, input logic [4:0] a3,
        input logic [DW-1:0] wd, input logic [4:0] a
    );
        if (a == 0) return '0;
        if (!rst) return '0;
        if (we && a3 != 0 && a == a3) return wd;
        return mem[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        cnt_m = 0;
        err_m = 1'b0;
    endtask

    task automatic cyc(
        input string tag, input bit rst, input bit we,
        input logic [4:0] a3, input logic [DW-1:0] wd,
        input logic [1:0] tn, input logic [4:0] a1,
        input logic [4:0] a2
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst;
        bus.RegWE_i = we;
        bus.a3_i = a3;
        bus.wd_i = wd;
        bus.pc_i = 32'h0040_3000 + $urandom_range(0, 255) * 4;
        bus.Tnew_i = tn;
        bus.a1_i = a1;
        bus.a2_i = a2;
        if (!rst) model_clear();
        e.rd1 = model_rd(rst, we, a3, wd, a1);
        e.rd2 = model_rd(rst, we, a3, wd, a2);
        e.wcnt = CW'(cnt_m % 16);
        e.err = err_m;
        e.tag = tag;
        q.push_back(e);
        if (rst) begin
            if (we && a3 != 0) begin
                mem[a3] = wd;
                cnt_m = (cnt_m + 1) % 16;
            end
            if (we && tn != 0) err_m = 1'b1;
        end
    endtask

    task automatic idle(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        cyc(tag, 1'b1, 1'b0, 5'($urandom), $urandom, 2'($urandom), a1, a2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.rd1_o !== e.rd1) begin
                errors++;
                $display("FAIL %s rd1 got %h exp %h", e.tag, bus.rd1_o, e.rd1);
            end
            checks++;
            if (bus.rd2_o !== e.rd2) begin
                errors++;
                $display("FAIL %s rd2 got %h exp %h", e.tag, bus.rd2_o, e.rd2);
            end
            checks++;
            if (bus.wcnt_o !== e.wcnt) begin
                errors++;
                $display("FAIL %s wcnt got %0d exp %0d", e.tag, bus.wcnt_o, e.wcnt);
            end
            checks++;
            if (bus.err_o !== e.err) begin
                errors++;
                $display("FAIL %s err got %b exp %b", e.tag, bus.err_o, e.err);
            end
        end
    end

    initial begin
        int waitc;
        logic [4:0] a3;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [1:0] tn;
        bit we;
        bit rst;
        model_clear();
        bus.RegWE_i = 1'b0;
        bus.a3_i = '0;
        bus.wd_i = '0;
        bus.pc_i = '0;
        bus.Tnew_i = '0;
        bus.a1_i = '0;
        bus.a2_i = '0;

        cyc("rst_hold", 1'b0, 1'b0, 5'd0, 32'h0, 2'd0, 5'd5, 5'd31);
        cyc("rst_we", 1'b0, 1'b1, 5'd5, 32'hAAAA_5555, 2'd1, 5'd5, 5'd31);
        idle("rst_rel", 5'd5, 5'd31);

        cyc("wr8", 1'b1, 1'b1, 5'd8, 32'h1234_5678, 2'd0, 5'd0, 5'd8);
        idle("rd8", 5'd8, 5'd8);

        cyc("byp9", 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 2'd0, 5'd9, 5'd9);
        idle("rd9", 5'd9, 5'd8);

        cyc("wr0", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 2'd0, 5'd0, 5'd0);
        idle("rd0", 5'd0, 5'd0);

        cyc("tnew", 1'b1, 1'b1, 5'd3, 32'h7, 2'd1, 5'd3, 5'd3);
        cyc("clean", 1'b1, 1'b1, 5'd4, 32'h5, 2'd0, 5'd3, 5'd4);
        idle("sticky", 5'd3, 5'd4);
        cyc("midrst", 1'b0, 1'b0, 5'd0, 32'h0, 2'd0, 5'd3, 5'd8);
        idle("postrst", 5'd3, 5'd9);

        for (int i = 0; i < 17; i++) begin
            a3 = 5'(1 + (i % 31));
            cyc("wrap_wr", 1'b1, 1'b1, a3, $urandom, 2'd0, a3, 5'($urandom));
            idle("wrap_idle", a3, 5'($urandom));
        end

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) != 0);
            we = $urandom_range(0, 1) == 1;
            a3 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            tn = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            a1 = $urandom_range(0, 1) ? a3 : 5'($urandom);
            a2 = $urandom_range(0, 2) == 0 ? a3 : 5'($urandom);
            if (!we) tn = 2'($urandom);
            cyc("rand", rst, we, a3, $urandom, tn, a1, a2);
        end

        waitc = 0;
        while (q.size() > 0 && waitc < 10) begin
            @(negedge clk);
            waitc++;
        end
        #1;
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain left %0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
